slot24_mux: RTL and testbench
=============================

Name: slot24_mux

Overview:
- Upstream stimulus/serialiser for the 24-slot time-multiplexed operator stream (6 channels x 4 operators).
- Holds one value per channel/operator, emits them one per clk_en in hardware slot order, and presents the matching 5-bit slot count on cnt.
- Its mixed/cnt pair feeds the per-slot separation stage directly.
- Double-buffered: software writes a shadow bank; it is committed to the active bank only at a frame boundary, so a frame never mixes old and new data.

Parameters:
- width, 10, data width of each slot value and of mixed.
- pos0, 0, slot offset (0..23) applied to cnt; must equal the downstream separator's pos0 so that (cnt+pos0)%24 recovers the internal slot.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- clk_en  in  1  slot advance enable; one slot per clk_en cycle
- wr_en  in  1  shadow-bank write strobe (any cycle, ignores clk_en)
- wr_addr  in  5  logical index L = op*6+ch, op 0..3 = S1..S4, ch 0..5; values 24..31 ignored
- wr_data  in  width  value to write
- commit  in  1  request shadow->active copy at next frame boundary
- commit_pend  out  1  commit requested, not yet applied
- cnt  out  5  slot count for the current mixed value
- mixed  out  width  serialised slot value
- frame_start  out  1  high while mixed/cnt carry internal slot 0

Behaviour:
- Internal slot counter slot[4:0]: reset 0; on clk_en, 0..22 increments, 23 wraps to 0. Values 24..31 never occur.
- Slot-to-logical map for slot k: ch = k%6; op from k/6: 0->S1(op0), 1->S3(op2), 2->S2(op1), 3->S4(op3). L = op*6+ch.
  - Examples: k=6 -> L=12; k=12 -> L=6; k=23 -> L=23.
- Output update, on a clk_en edge with slot=k: mixed <= active[L(k)]; cnt <= (k+24-pos0)%24; frame_start <= (k==0). Then slot advances.
  - mixed, cnt and frame_start always update together: the pair is coherent at every clk_en edge.
  - Latency: 1 clk from slot selection to output.
- clk_en low: slot, cnt, mixed, frame_start, active bank and the copy all hold. Shadow writes and commit capture still operate.
- Shadow write: wr_en=1 and wr_addr<24 -> shadow[wr_addr] <= wr_data on that edge. wr_addr>=24: no effect.
- Commit flag:
  - commit=1 sets commit_pend on the next edge.
  - Boundary edge = clk_en=1 and slot==23. At a boundary edge with commit_pend=1: active <= shadow (all 24 entries, single edge) and commit_pend <= 0.
  - Slot 0 of the next frame emits committed data.
- Simultaneous events:
  - wr_en on the boundary copy edge: the copy takes the pre-write shadow contents; the new value lands in shadow only.
  - commit=1 on the copy edge: copy proceeds and commit_pend stays 1, so a second copy occurs at the following boundary.
  - commit while already pending: no additional effect.
  - Repeated writes to the same address before a commit: last write wins.
- Reset (any time, including mid-frame): slot=0, cnt=0, mixed=0, frame_start=0, commit_pend=0, both banks cleared to 0. The first clk_en after reset emits slot 0.
- Arithmetic: cnt offset computed modulo 24 in 6-bit intermediate; no truncation of mixed, which is a straight copy.

Test Plan:
- Reset, write shadow[L]=L+1 for L=0..23, commit, run 48 clk_en -> first frame mixed all 0; second frame mixed sequence 1..6,13..18,7..12,19..24 with cnt 0..23 and frame_start only with cnt=0.
- pos0=5, same data -> cnt sequence 19,20,21,22,23,0,1,...; (cnt+5)%24 equals internal slot; frame_start coincides with cnt=19.
- clk_en toggled 1-in-3, mid-frame write to shadow without commit -> outputs change only on clk_en edges, mixed never shows unwritten-commit data, slot never skips.
- wr_en to L=0 with 0x3FF exactly on the boundary copy edge (commit pending, old shadow[0]=7) -> next frame slot0 mixed=7; after a further commit, slot0 mixed=0x3FF.
- commit asserted on the copy edge -> commit_pend stays 1 after that edge, clears after the next boundary; wr_addr=24..31 writes -> no bank change.
- rst asserted at slot 14 with commit_pend=1 -> next edge: cnt=0, mixed=0, commit_pend=0; first clk_en emits slot 0 with value 0.

Source files
------------

// File: rtl/slot24_mux_if.sv
// Bus bundle for the 24-slot serialiser: shadow-bank write port, commit
// request, and the serialised mixed/cnt/frame_start stream.
//
// Strobe semantics (no valid/ready back-pressure on this bus):
//   - clk_en advances the stream by exactly one slot on each cycle it is high.
//     mixed/cnt/frame_start change only on those edges and always together.
//   - wr_en writes wr_data into shadow[wr_addr] on any edge (clk_en is ignored).
//     Addresses 24..31 are dropped.
//   - commit is a one-edge request. It is reflected on commit_pend and is
//     consumed at the next frame boundary.
interface slot24_mux_if #(
    parameter int width = 10
);
    logic             clk_en;
    logic             wr_en;
    logic [4:0]       wr_addr;
    logic [width-1:0] wr_data;
    logic             commit;
    logic             commit_pend;
    logic [4:0]       cnt;
    logic [width-1:0] mixed;
    logic             frame_start;

    // Stimulus side: drives the controls and observes the stream.
    modport master (
        output clk_en, wr_en, wr_addr, wr_data, commit,
        input  commit_pend, cnt, mixed, frame_start
    );

    // Serialiser side.
    modport slave (
        input  clk_en, wr_en, wr_addr, wr_data, commit,
        output commit_pend, cnt, mixed, frame_start
    );
endinterface

// File: rtl/slot24_mux.sv
// slot24_mux: a double-buffered serialiser for the 6-channel x 4-operator
// slot stream. Software fills a shadow bank. A commit copies the whole shadow
// bank into the active bank at a frame boundary, so that no frame mixes old
// and new data.
module slot24_mux #(
    parameter int width = 10,
    parameter int pos0  = 0
) (
    input  logic        clk,
    input  logic        rst,
    slot24_mux_if.slave bus
);
    localparam logic [5:0] c_pos0 = 6'(pos0);

    logic [4:0]       r_slot;
    logic             r_pend;
    logic [4:0]       r_cnt;
    logic [width-1:0] r_mixed;
    logic             r_frame_start;
    logic [width-1:0] r_shadow [0:23];
    logic [width-1:0] r_active [0:23];

    logic [2:0]       w_ch;
    logic [1:0]       w_grp;
    logic [1:0]       w_op;
    logic [4:0]       w_lidx;
    logic [5:0]       w_cnt_sum;
    logic [4:0]       w_cnt_next;
    logic             w_boundary;
    logic             w_copy;

    // Map the hardware slot to its logical index and to its offset count.
    // The hardware groups run S1,S3,S2,S4. The group to operator map swaps the two group bits.
    always_comb begin
        w_ch       = 3'(r_slot % 5'd6);
        w_grp      = 2'(r_slot / 5'd6);
        w_op       = {w_grp[0], w_grp[1]};
        w_lidx     = 5'({3'b000, w_op} * 5'd6 + {2'b00, w_ch});
        w_cnt_sum  = {1'b0, r_slot} + 6'd24 - c_pos0;
        w_cnt_next = (w_cnt_sum >= 6'd24) ? 5'(w_cnt_sum - 6'd24) : w_cnt_sum[4:0];
        w_boundary = bus.clk_en && (r_slot == 5'd23);
        w_copy     = w_boundary && r_pend;
    end

    // Slot counter: 0..23 with wrap, and it advances only on clk_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot <= 5'd0;
        end else if (bus.clk_en) begin
            r_slot <= (r_slot == 5'd23) ? 5'd0 : r_slot + 5'd1;
        end
    end

    // Output register: mixed, cnt and frame_start load together so the pair stays coherent.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mixed       <= '0;
            r_cnt         <= 5'd0;
            r_frame_start <= 1'b0;
        end else if (bus.clk_en) begin
            r_mixed       <= r_active[w_lidx];
            r_cnt         <= w_cnt_next;
            r_frame_start <= (r_slot == 5'd0);
        end
    end

    // Shadow bank: free-running writes. Out-of-range addresses are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 24; i++) r_shadow[i] <= '0;
        end else if (bus.wr_en && (bus.wr_addr < 5'd24)) begin
            r_shadow[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Active bank: a whole-bank copy on the boundary edge. A write on the same edge misses the copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 24; i++) r_active[i] <= '0;
        end else if (w_copy) begin
            for (int i = 0; i < 24; i++) r_active[i] <= r_shadow[i];
        end
    end

    // Commit flag: a new request wins over the clear, so a commit on the copy edge re-arms it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= 1'b0;
        end else if (bus.commit) begin
            r_pend <= 1'b1;
        end else if (w_copy) begin
            r_pend <= 1'b0;
        end
    end

    assign bus.mixed       = r_mixed;
    assign bus.cnt         = r_cnt;
    assign bus.frame_start = r_frame_start;
    assign bus.commit_pend = r_pend;
endmodule

// File: tb/tb_slot24_mux.sv
// Bench for slot24_mux. Two instances, with pos0=0 and pos0=5, get the same stimulus.
// Expected stream entries are queued when clk_en is driven and popped after the edge.
module tb_slot24_mux;
    localparam int WIDTH = 10;
    localparam int W     = 1 + 5 + WIDTH;

    logic clk;
    logic rst;

    slot24_mux_if #(.width(WIDTH)) bus0 ();
    slot24_mux_if #(.width(WIDTH)) bus5 ();

    slot24_mux #(.width(WIDTH), .pos0(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    slot24_mux #(.width(WIDTH), .pos0(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5.slave));

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [W-1:0]     exp_q[$];
    int               m_slot;
    logic             m_pend;
    logic [WIDTH-1:0] m_shadow [0:23];
    logic [WIDTH-1:0] m_active [0:23];
    logic             h_fs;
    logic [4:0]       h_cnt;
    logic [4:0]       h_cnt5;
    logic [WIDTH-1:0] h_mixed;
    int               op_tab [0:3] = '{0, 2, 1, 3};

    function automatic int lidx(input int k);
        return op_tab[k / 6] * 6 + (k % 6);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic en, input logic we, input logic [4:0] a,
                         input logic [WIDTH-1:0] d, input logic cm);
        bus0.clk_en = en; bus0.wr_en = we; bus0.wr_addr = a; bus0.wr_data = d; bus0.commit = cm;
        bus5.clk_en = en; bus5.wr_en = we; bus5.wr_addr = a; bus5.wr_data = d; bus5.commit = cm;
    endtask

    // One clock: drive the inputs, update the reference model, then check both DUTs after the edge.
    task automatic cycle(input logic en, input logic we, input logic [4:0] a,
                         input logic [WIDTH-1:0] d, input logic cm);
        logic [W-1:0] e;
        logic         bnd;
        drive(en, we, a, d, cm);
        if (en) exp_q.push_back({(m_slot == 0), 5'(m_slot), m_active[lidx(m_slot)]});
        bnd = en && (m_slot == 23);
        if (bnd && m_pend) for (int i = 0; i < 24; i++) m_active[i] = m_shadow[i];
        if (we && a < 5'd24) m_shadow[a] = d;
        if (cm) m_pend = 1'b1;
        else if (bnd) m_pend = 1'b0;
        if (en) m_slot = (m_slot == 23) ? 0 : m_slot + 1;
        @(posedge clk);
        #1;
        if (en) begin
            e       = exp_q.pop_front();
            h_fs    = e[W-1];
            h_cnt   = e[W-2 -: 5];
            h_mixed = e[WIDTH-1:0];
            h_cnt5  = 5'((int'(h_cnt) + 19) % 24);
        end
        chk("mixed", 32'(bus0.mixed), 32'(h_mixed));
        chk("cnt", 32'(bus0.cnt), 32'(h_cnt));
        chk("frame_start", 32'(bus0.frame_start), 32'(h_fs));
        chk("commit_pend", 32'(bus0.commit_pend), 32'(m_pend));
        chk("mixed_p5", 32'(bus5.mixed), 32'(h_mixed));
        chk("cnt_p5", 32'(bus5.cnt), 32'(h_cnt5));
        chk("frame_start_p5", 32'(bus5.frame_start), 32'(h_fs));
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 5'd0, '0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_slot = 0;
        m_pend = 1'b0;
        for (int i = 0; i < 24; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
        end
        h_fs = 1'b0; h_cnt = 5'd0; h_cnt5 = 5'd0; h_mixed = '0;
        exp_q.delete();
        chk("rst_cnt", 32'(bus0.cnt), 32'd0);
        chk("rst_mixed", 32'(bus0.mixed), 32'd0);
        chk("rst_frame_start", 32'(bus0.frame_start), 32'd0);
        chk("rst_commit_pend", 32'(bus0.commit_pend), 32'd0);
        chk("rst_cnt_p5", 32'(bus5.cnt), 32'd0);
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 24 && m_slot != target; i++) cycle(1'b1, 1'b0, 5'd0, '0, 1'b0);
    endtask

    // Directed sequence
    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 5'd0, '0, 1'b0);
        do_reset();

        // Fill the shadow bank with L+1, commit, and run two frames.
        for (int l = 0; l < 24; l++) cycle(1'b0, 1'b1, 5'(l), WIDTH'(l + 1), 1'b0);
        cycle(1'b0, 1'b0, 5'd0, '0, 1'b1);
        for (int i = 0; i < 48; i++) cycle(1'b1, 1'b0, 5'd0, '0, 1'b0);
        chk("frame2_last_mixed", 32'(bus0.mixed), 32'd24);

        // Enable clk_en one cycle in three, with shadow writes mid-frame and no commit.
        for (int i = 0; i < 72; i++)
            cycle((i % 3) == 2, (i % 7) == 3, 5'($urandom_range(0, 23)),
                  WIDTH'($urandom_range(0, 1023)), 1'b0);

        // A write lands on the copy edge: the copy keeps the old shadow[0]=7.
        cycle(1'b0, 1'b1, 5'd0, WIDTH'(7), 1'b0);
        cycle(1'b0, 1'b0, 5'd0, '0, 1'b1);
        run_to(23);
        cycle(1'b1, 1'b1, 5'd0, WIDTH'(10'h3FF), 1'b0);
        cycle(1'b1, 1'b0, 5'd0, '0, 1'b0);
        chk("copy_edge_slot0", 32'(bus0.mixed), 32'd7);
        cycle(1'b0, 1'b0, 5'd0, '0, 1'b1);
        run_to(23);
        cycle(1'b1, 1'b0, 5'd0, '0, 1'b0);
        cycle(1'b1, 1'b0, 5'd0, '0, 1'b0);
        chk("recommit_slot0", 32'(bus0.mixed), 32'h3FF);

        // A commit on the copy edge keeps the commit pending for one more boundary.
        cycle(1'b0, 1'b0, 5'd0, '0, 1'b1);
        run_to(23);
        cycle(1'b1, 1'b0, 5'd0, '0, 1'b1);
        chk("pend_after_copy_commit", 32'(bus0.commit_pend), 32'd1);
        run_to(23);
        cycle(1'b1, 1'b0, 5'd0, '0, 1'b0);
        chk("pend_cleared", 32'(bus0.commit_pend), 32'd0);

        // Writes to addresses 24..31 change neither bank.
        for (int a = 24; a < 32; a++) cycle(1'b0, 1'b1, 5'(a), WIDTH'($urandom_range(0, 1023)), 1'b0);
        cycle(1'b0, 1'b0, 5'd0, '0, 1'b1);
        for (int i = 0; i < 48; i++) cycle(1'b1, 1'b0, 5'd0, '0, 1'b0);

        // Reset mid-frame at slot 14 while a commit is pending.
        cycle(1'b0, 1'b0, 5'd0, '0, 1'b1);
        run_to(14);
        do_reset();
        cycle(1'b1, 1'b0, 5'd0, '0, 1'b0);
        chk("post_rst_cnt", 32'(bus0.cnt), 32'd0);
        chk("post_rst_mixed", 32'(bus0.mixed), 32'd0);
        chk("post_rst_frame_start", 32'(bus0.frame_start), 32'd1);
        chk("post_rst_cnt_p5", 32'(bus5.cnt), 32'd19);

        // Final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
